isqrt_square: RTL and testbench

ISQRT_SQUARE -- requirements
Module: isqrt_square

---
 rtl/isqrt_square.sv | 106 ++++++++++
 tb/tb_isqrt_square.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_square.sv
// rtl/isqrt_square.sv - rebuilds a radicand from an integer square root (shift-add squarer)
// Optional remainder add-back: define ISQRT_SQUARE_REM_EN.
module isqrt_square #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH/2-1:0] root,
  input  logic [WIDTH/2:0]   rem,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   square,
  output logic               overflow
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    root_q;
  logic [CW-1:0]   k;
  logic [WIDTH:0]  acc, acc_nxt, addend;
  logic            last;

`ifdef ISQRT_SQUARE_REM_EN
  logic [N:0]      rem_q;
`else
  logic            unused_rem;
  assign unused_rem = ^rem;
`endif

  assign last = (k == CW'(N - 1));

  // One partial product per cycle; the extra top bit keeps the sum untruncated.
  always_comb begin
    addend  = root_q[k] ? ((WIDTH+1)'(root_q) << k) : '0;
    acc_nxt = acc + addend;
`ifdef ISQRT_SQUARE_REM_EN
    if (last) acc_nxt = acc_nxt + (WIDTH+1)'(rem_q);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      root_q   <= '0;
      k        <= '0;
      acc      <= '0;
      square   <= '0;
      overflow <= 1'b0;
`ifdef ISQRT_SQUARE_REM_EN
      rem_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            root_q <= root;
            acc    <= '0;
            k      <= '0;
`ifdef ISQRT_SQUARE_REM_EN
            rem_q  <= rem;
`endif
          end
        end
        RUN: begin
          acc <= acc_nxt;
          k   <= k + CW'(1);
          // Without the remainder root*root never reaches bit WIDTH, so overflow stays 0.
          if (last) begin
            square   <= acc_nxt[WIDTH-1:0];
            overflow <= acc_nxt[WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_isqrt_square.sv
// tb/tb_isqrt_square.sv - self-checking bench for isqrt_square with a timing/arithmetic model
// Honours ISQRT_SQUARE_REM_EN the same way the design does.
module tb_isqrt_square;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [N-1:0]     root = '0;
  logic [N:0]       rem = '0;
  logic             busy, done, overflow;
  logic [WIDTH-1:0] square;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  isqrt_square #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .root(root), .rem(rem),
    .busy(busy), .done(done), .square(square), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model: an accepted start keeps the block busy for N+1 cycles, the last of which is done.
  int               busy_left = 0;
  logic [WIDTH-1:0] m_sq = '0;
  logic             m_ov = 1'b0;
  logic [WIDTH-1:0] p_sq = '0;
  logic             p_ov = 1'b0;

  always @(posedge clk or negedge reset) begin
    longint e;
    if (!reset) begin
      busy_left = 0;
      m_sq      = '0;
      m_ov      = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 1) begin
        m_sq = p_sq;
        m_ov = p_ov;
      end
    end else if (start) begin
      e = longint'(root) * longint'(root);
`ifdef ISQRT_SQUARE_REM_EN
      e = e + longint'(rem);
`endif
      p_sq      = WIDTH'(e);
      p_ov      = (e >= (64'd1 << WIDTH));
      busy_left = N + 1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    chk("busy",     busy,     busy_left > 0);
    chk("done",     done,     busy_left == 1);
    chk("square",   square,   m_sq);
    chk("overflow", overflow, m_ov);
  end

  task automatic pulse_start(input logic [N-1:0] r, input logic [N:0] m);
    @(posedge clk); #2;
    root  = r;
    rem   = m;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [N-1:0] r, input logic [N:0] m,
                        output logic [WIDTH-1:0] sq, output logic ov,
                        output int lat, output int bc);
    bit seen = 0;
    pulse_start(r, m);
    lat = 0;
    bc  = 0;
    sq  = '0;
    ov  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (done) begin
        seen = 1;
        sq   = square;
        ov   = overflow;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout waiting for done (root=%0d)", r);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && busy; i++) @(negedge clk);
    chk("wait_idle", busy, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] sq;
    logic             ov;
    int               lat, bc, ndone, last_c;
    logic [31:0]      rnd;

    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_square", square, 0);
    chk("reset_overflow", overflow, 0);
    @(posedge clk); #2 reset = 1'b1;

    // root=12, rem=3
    run_op(8'd12, 9'd3, sq, ov, lat, bc);
    chk("r12_latency", lat, 9);
`ifdef ISQRT_SQUARE_REM_EN
    chk("r12_square", sq, 147);
`else
    chk("r12_square", sq, 144);
`endif
    chk("r12_overflow", ov, 0);

    // full-scale root, with and without carry out
`ifdef ISQRT_SQUARE_REM_EN
    run_op(8'hFF, 9'h1FE, sq, ov, lat, bc);
    chk("ff_1fe_square", sq, 16'hFFFF);
    chk("ff_1fe_overflow", ov, 0);
    run_op(8'hFF, 9'h1FF, sq, ov, lat, bc);
    chk("ff_1ff_square", sq, 16'h0000);
    chk("ff_1ff_overflow", ov, 1);
`else
    run_op(8'hFF, 9'h1FF, sq, ov, lat, bc);
    chk("ff_square", sq, 16'hFE01);
    chk("ff_overflow", ov, 0);
`endif

    // zero operand and busy width
    run_op(8'd0, 9'd0, sq, ov, lat, bc);
    chk("zero_latency", lat, 9);
    chk("zero_busy_cycles", bc, 9);
    chk("zero_square", sq, 0);
    chk("zero_overflow", ov, 0);
    @(negedge clk);
    chk("zero_busy_after", busy, 0);

    // second start while busy is dropped
    pulse_start(8'd5, 9'd2);
    repeat (2) @(posedge clk);
    #2 root = 8'd9; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    ndone = 0;
    sq = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        sq = square;
      end
    end
    chk("ignore_done_count", ndone, 1);
`ifdef ISQRT_SQUARE_REM_EN
    chk("ignore_square", sq, 27);
`else
    chk("ignore_square", sq, 25);
`endif

    // reset mid-operation
    pulse_start(8'd200, 9'd5);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_square", square, 0);
    chk("abort_overflow", overflow, 0);
    @(posedge clk); #2 reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op(8'd200, 9'd0, sq, ov, lat, bc);
    chk("after_reset_square", sq, 40000);
    chk("after_reset_overflow", ov, 0);
    chk("after_reset_latency", lat, 9);

    // back-to-back with start held high
    @(posedge clk); #2 start = 1'b1;
    ndone  = 0;
    last_c = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) begin
        if (last_c >= 0) chk("b2b_period", c - last_c, 10);
        last_c = c;
        ndone++;
      end
      @(posedge clk); #2;
      rnd  = $urandom;
      root = rnd[N-1:0];
      rem  = rnd[N+8:8];
    end
    chk("b2b_done_count", ndone >= 5, 1);
    start = 1'b0;
    wait_idle();

    // random traffic, including occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #2;
      rnd   = $urandom;
      root  = ($urandom_range(0, 4) == 0) ? '1 : rnd[N-1:0];
      rem   = ($urandom_range(0, 4) == 0) ? '1 : rnd[N+16:16];
      start = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 79) != 0);
    end
    @(posedge clk); #2;
    reset = 1'b1;
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
